vga_timing_gen: RTL and testbench



---
 rtl/vga_pkg.sv | 18 +
 rtl/vga_axis_counter.sv | 54 +++++
 rtl/vga_timing_gen.sv | 177 +++++++++++++++++
 tb/tb_vga_timing_gen.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants: 640x480@60 defaults and sync polarity levels.
// Imported by vga_axis_counter and vga_timing_gen.
package vga_pkg;

  localparam int H_ACTIVE_640 = 640;
  localparam int H_FP_640     = 16;
  localparam int H_SYNC_640   = 96;
  localparam int H_BP_640     = 48;

  localparam int V_ACTIVE_480 = 480;
  localparam int V_FP_480     = 10;
  localparam int V_SYNC_480   = 2;
  localparam int V_BP_480     = 33;

  localparam logic SYNC_ACT_LOW  = 1'b0;
  localparam logic SYNC_ACT_HIGH = 1'b1;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with active/sync decode.
// Ports: clk, rst, step (advance) -> count, wrap (at last), active, sync.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int   ACTIVE = H_ACTIVE_640,
  parameter int   FP     = H_FP_640,
  parameter int   SYNC   = H_SYNC_640,
  parameter int   BP     = H_BP_640,
  parameter logic POL    = SYNC_ACT_LOW,
  parameter int   W      = $clog2(ACTIVE + FP + SYNC + BP)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         active,
  output logic         sync
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;

  // One extra bit so window bounds equal to TOTAL still fit.
  localparam logic [W:0] ACT_END  = (W + 1)'(ACTIVE);
  localparam logic [W:0] SYN_BEG  = (W + 1)'(ACTIVE + FP);
  localparam logic [W:0] SYN_END  = (W + 1)'(ACTIVE + FP + SYNC);
  localparam logic [W-1:0] LAST   = W'(TOTAL - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic [W:0]   cnt_ext;
  logic         in_sync;

  always_comb begin
    count_d = count_q;
    if (step) begin
      count_d = wrap ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign cnt_ext = {1'b0, count_q};
  assign in_sync = (cnt_ext >= SYN_BEG) && (cnt_ext < SYN_END);
  assign count   = count_q;
  assign wrap    = (count_q == LAST);
  assign active  = (cnt_ext < ACT_END);
  assign sync    = in_sync ? POL : ~POL;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: syncs, display enable, coordinates, pulses.
// Ports: clk, rst, ena -> pix_stb, x, y, de, hsync, vsync, line_start,
// frame_start, frame_cnt (only with VGA_TIMING_FRAME_CNT_EN defined).
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE   = H_ACTIVE_640,
  parameter int   H_FP       = H_FP_640,
  parameter int   H_SYNC     = H_SYNC_640,
  parameter int   H_BP       = H_BP_640,
  parameter int   V_ACTIVE   = V_ACTIVE_480,
  parameter int   V_FP       = V_FP_480,
  parameter int   V_SYNC     = V_SYNC_480,
  parameter int   V_BP       = V_BP_480,
  parameter logic H_SYNC_POL = SYNC_ACT_LOW,
  parameter logic V_SYNC_POL = SYNC_ACT_LOW,
  parameter int   PIX_DIV    = 1,
  parameter int   FRAME_W    = 8,
  parameter int   H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP,
  parameter int   V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP,
  parameter int   X_W        = $clog2(H_TOTAL),
  parameter int   Y_W        = $clog2(V_TOTAL)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  output logic               pix_stb,
  output logic [X_W-1:0]     x,
  output logic [Y_W-1:0]     y,
  output logic               de,
  output logic               hsync,
  output logic               vsync,
  output logic               line_start,
  output logic               frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [FRAME_W-1:0] frame_cnt
`endif
);

  localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             load, tick;

  logic [X_W-1:0] h_count;
  logic [Y_W-1:0] v_count;
  logic h_wrap, h_act, h_sync_lvl;
  logic v_wrap, v_act, v_sync_lvl;

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic de_q, de_d;
  logic hs_q, hs_d;
  logic vs_q, vs_d;
  logic stb_q, stb_d;
  logic ls_q, ls_d;
  logic fs_q, fs_d;

  // Outputs load the pending pixel on the first cycle of each pixel
  // period; the counters move on the last, so after reset the very first
  // enabled edge already presents (0,0) whatever PIX_DIV is.
  assign load = ena && (div_q == '0);
  assign tick = ena && (div_q == DIV_LAST);

  always_comb begin
    div_d = div_q;
    if (ena) div_d = tick ? '0 : div_q + DIV_W'(1);
  end

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
    .POL(H_SYNC_POL), .W(X_W)
  ) u_h (
    .clk(clk), .rst(rst), .step(tick),
    .count(h_count), .wrap(h_wrap),
    .active(h_act), .sync(h_sync_lvl)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
    .POL(V_SYNC_POL), .W(Y_W)
  ) u_v (
    .clk(clk), .rst(rst), .step(tick && h_wrap),
    .count(v_count), .wrap(v_wrap),
    .active(v_act), .sync(v_sync_lvl)
  );

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    de_d  = de_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    stb_d = 1'b0;
    ls_d  = 1'b0;
    fs_d  = 1'b0;
    if (load) begin
      x_d   = h_count;
      y_d   = v_count;
      de_d  = h_act && v_act;
      hs_d  = h_sync_lvl;
      vs_d  = v_sync_lvl;
      stb_d = 1'b1;
      ls_d  = (h_count == '0);
      fs_d  = (h_count == '0) && (v_count == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
      de_q  <= 1'b0;
      hs_q  <= ~H_SYNC_POL;
      vs_q  <= ~V_SYNC_POL;
      stb_q <= 1'b0;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      x_q   <= x_d;
      y_q   <= y_d;
      de_q  <= de_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      stb_q <= stb_d;
      ls_q  <= ls_d;
      fs_q  <= fs_d;
    end
  end

  assign pix_stb     = stb_q;
  assign x           = x_q;
  assign y           = y_q;
  assign de          = de_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FRAME_W-1:0] fcnt_q, fcnt_d;
  logic               seen_q, seen_d;

  // The frame shown right after reset is frame 0; only later frame starts
  // mark a completed frame.
  always_comb begin
    fcnt_d = fcnt_q;
    seen_d = seen_q;
    if (fs_d) begin
      seen_d = 1'b1;
      if (seen_q) fcnt_d = fcnt_q + FRAME_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q <= '0;
      seen_q <= 1'b0;
    end else begin
      fcnt_q <= fcnt_d;
      seen_q <= seen_d;
    end
  end

  assign frame_cnt = fcnt_q;
`else
  localparam int frame_w_unused = FRAME_W;
`endif

  logic unused_v_wrap;
  assign unused_v_wrap = v_wrap;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a 14x8 raster (8/2/3/1, 4/1/2/1).
// Covers reset, sync windows, wrap, PIX_DIV=3, ena freeze, mid-frame reset.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ena0 = 1'b1;
  logic ena1 = 1'b1;

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic       stb0, de0, hs0, vs0, ls0, fs0;
  logic [3:0] x0;
  logic [2:0] y0;
  logic       stb1, de1, hs1, vs1, ls1, fs1;
  logic [3:0] x1;
  logic [2:0] y1;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] fc0, fc1;
  logic       stb2, de2, hs2, vs2, ls2, fs2;
  logic [3:0] x2;
  logic [2:0] y2;
  logic [1:0] fc2;
`endif

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIX_DIV(1)
  ) u0 (
    .clk(clk), .rst(rst), .ena(ena0), .pix_stb(stb0),
    .x(x0), .y(y0), .de(de0), .hsync(hs0), .vsync(vs0),
    .line_start(ls0), .frame_start(fs0)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(fc0)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIX_DIV(3)
  ) u1 (
    .clk(clk), .rst(rst), .ena(ena1), .pix_stb(stb1),
    .x(x1), .y(y1), .de(de1), .hsync(hs1), .vsync(vs1),
    .line_start(ls1), .frame_start(fs1)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(fc1)
`endif
  );

`ifdef VGA_TIMING_FRAME_CNT_EN
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIX_DIV(1),
    .H_SYNC_POL(1'b1), .FRAME_W(2)
  ) u2 (
    .clk(clk), .rst(rst), .ena(ena1), .pix_stb(stb2),
    .x(x2), .y(y2), .de(de2), .hsync(hs2), .vsync(vs2),
    .line_start(ls2), .frame_start(fs2), .frame_cnt(fc2)
  );
`endif

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ex, ey;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_x", x0, 0);
    chk("rst_y", y0, 0);
    chk("rst_de", de0, 0);
    chk("rst_hs", hs0, 1);
    chk("rst_vs", vs0, 1);
    chk("rst_stb", stb0, 0);
    chk("rst_fs", fs0, 0);

    // Two full frames at PIX_DIV=1 against the hand-derived window table
    rst = 1'b0;
    for (int c = 0; c < 224; c++) begin
      tick();
      ex = c % 14;
      ey = (c / 14) % 8;
      chk("p1_x", x0, ex);
      chk("p1_y", y0, ey);
      chk("p1_stb", stb0, 1);
      chk("p1_de", de0, int'(ex < 8 && ey < 4));
      chk("p1_hs", hs0, int'(!(ex >= 10 && ex <= 12)));
      chk("p1_vs", vs0, int'(!(ey >= 5 && ey <= 6)));
      chk("p1_ls", ls0, int'(ex == 0));
      chk("p1_fs", fs0, int'(ex == 0 && ey == 0));
    end

    // ena freeze at (6,2)
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c <= 34; c++) tick();
    chk("fz_pre_x", x0, 6);
    chk("fz_pre_y", y0, 2);
    ena0 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("fz_x", x0, 6);
      chk("fz_y", y0, 2);
      chk("fz_stb", stb0, 0);
      chk("fz_ls", ls0, 0);
      chk("fz_de", de0, 1);
    end
    ena0 = 1'b1;
    tick();
    chk("fz_x_next", x0, 7);
    chk("fz_y_next", y0, 2);
    chk("fz_stb_next", stb0, 1);

    // Mid-frame reset at (9,3)
    for (int c = 0; c < 16; c++) tick();
    chk("mr_pre_x", x0, 9);
    chk("mr_pre_y", y0, 3);
    rst = 1'b1;
    tick();
    chk("mr_x", x0, 0);
    chk("mr_y", y0, 0);
    chk("mr_de", de0, 0);
    chk("mr_hs", hs0, 1);
    chk("mr_vs", vs0, 1);
    chk("mr_fs", fs0, 0);
    rst = 1'b0;
    tick();
    chk("mr_rel_x", x0, 0);
    chk("mr_rel_y", y0, 0);
    chk("mr_rel_de", de0, 1);
    chk("mr_rel_fs", fs0, 1);

    // PIX_DIV=3: two lines, each pixel held three cycles
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 84; c++) begin
      tick();
      chk("d3_x", x1, (c / 3) % 14);
      chk("d3_y", y1, c / 42);
      chk("d3_stb", stb1, int'(c % 3 == 0));
      chk("d3_ls", ls1, int'(c % 42 == 0));
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    // Active-high hsync and 2-bit frame counter over five frame starts
    rst = 1'b1;
    tick();
    chk("fc_rst", fc2, 0);
    rst = 1'b0;
    for (int c = 0; c <= 448; c++) begin
      tick();
      ex = c % 14;
      if (c < 14) chk("fc_hs", hs2, int'(ex >= 10 && ex <= 12));
      if (c % 112 == 0) begin
        chk("fc_fs", fs2, 1);
        chk("fc_cnt", fc2, (c / 112) % 4);
      end
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
